reg_dump: RTL
=============

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0, first register index dumped.
REQ-002 SHALL have parameter LAST_REG, default 31, last register index dumped; FIRST_REG <= LAST_REG <= 31 is required.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request a dump sequence; level-sampled in IDLE only.
REQ-006 abort  input  1  terminate an active dump.
REQ-007 rf_ra  output  5  register-file read address.
REQ-008 rf_dout  input  32  register-file read data, combinational from rf_ra, same cycle.
REQ-009 out_valid  output  1  out_idx/out_data hold a captured register.
REQ-010 out_ready  input  1  sink accepts the current beat.
REQ-011 out_idx  output  5  index of the register in out_data.
REQ-012 out_data  output  32  captured register value.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-015 SHALL implement the states IDLE, READ, SEND and FIN.
REQ-016 IDLE: rf_ra=0 and out_valid=0; start=1 loads idx<=FIRST_REG and moves to READ.
REQ-017 READ (one cycle): rf_ra=idx; captures out_data<=rf_dout and out_idx<=idx; sets out_valid<=1; moves to SEND.
REQ-018 SEND: rf_ra=idx; out_valid, out_idx and out_data SHALL stay stable until out_valid&&out_ready.
REQ-019 SEND on handshake with idx!=LAST_REG: out_valid<=0, idx<=idx+1, move to READ.
REQ-020 SEND on handshake with idx==LAST_REG: out_valid<=0, move to FIN; idx SHALL NOT increment (no 5-bit wrap past 31).
REQ-021 FIN (one cycle): done=1, then move to IDLE; done SHALL be 0 in all other states.
REQ-022 Each register costs 2 cycles at best (READ + SEND with out_ready=1); a full 0..31 dump from start to done is 1+64+1 cycles.
REQ-023 Index 0 SHALL be read through rf_ra like any other register; the value returned is whatever rf_dout presents (0 for the team register file).
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 abort=1 in READ, SEND or FIN SHALL force IDLE on the next edge with out_valid<=0 and no done pulse; abort in IDLE has no effect; abort has priority over start and over a simultaneous handshake.
REQ-026 A handshake coincident with abort SHALL count as a delivered beat, but no further beats follow.
REQ-027 out_ready while out_valid=0 SHALL have no effect.
REQ-028 rf_ra SHALL be driven from registered state only, with no combinational path from out_ready or start.

Reset
REQ-029 On resetn=0 at a clock edge: state=IDLE, idx=0, out_valid=0, out_idx=0, out_data=0, done=0, busy=0, rf_ra=0.
REQ-030 Reset mid-sequence SHALL discard the in-flight beat with no done pulse; a new start is accepted from the first cycle after resetn returns to 1.

Structure
REQ-031 A shared package SHALL hold REG_ADDR_W=5, DATA_W=32 and the state enumeration type.
REQ-032 SHALL be a single module with no sub-modules; it connects to one read port of the register file (ra2/dout2 side), leaving the write port untouched.

Verification
REQ-033 Preload r1..r31 with 0x1000_0000+i, pulse start, out_ready=1 -> 32 beats, idx 0..31, data 0 then 0x1000_0001..0x1000_001F, done pulse at cycle 66.
REQ-034 FIRST_REG=5, LAST_REG=7, out_ready toggled 1/0 each cycle -> exactly 3 beats (5,6,7), data stable while stalled, one done pulse.
REQ-035 Hold out_ready=0 for 10 cycles on beat idx=3 -> out_valid, out_idx=3 and out_data constant throughout; rf_ra=3; beat then completes.
REQ-036 Assert abort in the SEND state for idx=12 -> IDLE next cycle, out_valid=0, done never asserted, busy=0.
REQ-037 Assert resetn=0 during READ for idx=20 -> all outputs 0 on the next cycle; a start after release dumps from FIRST_REG.
REQ-038 Pulse start again while busy at idx=4 -> ignored; the sequence count and done timing are identical to REQ-033.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// ---------------------------------------------------------------------------
// reg_dump_pkg
// Shared definitions for the register-dump sequencer.
//   REG_ADDR_W : register-file address width (32 registers)
//   DATA_W     : register width
//   state_t    : sequencer state enumeration (also exported on dbg_state)
// ---------------------------------------------------------------------------
package reg_dump_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/reg_dump_if.sv
// ---------------------------------------------------------------------------
// reg_dump_if
// Bundle of the control, register-file read port and output-stream signals
// of the register-dump sequencer.
//   start     : request a dump (sampled only while idle)
//   abort     : terminate an active dump
//   rf_ra     : register-file read address (ra2 side of the register file)
//   rf_dout   : register-file read data, combinational from rf_ra
//   out_valid : out_idx/out_data hold a captured register
//   out_ready : sink accepts the current beat
//   out_idx   : index of the register in out_data
//   out_data  : captured register value
//   busy      : sequencer is not idle
//   done      : one-cycle pulse on normal completion
//   dbg_state : current sequencer state, for observation only
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the beat
// (out_valid, out_idx, out_data) holds steady. out_ready while out_valid=0
// has no effect.
//
// modport master : the sequencer side
// modport slave  : the environment side (control source, register file, sink)
// ---------------------------------------------------------------------------
interface reg_dump_if;
    import reg_dump_pkg::*;

    logic      start;
    logic      abort;
    reg_addr_t rf_ra;
    data_t     rf_dout;
    logic      out_valid;
    logic      out_ready;
    reg_addr_t out_idx;
    data_t     out_data;
    logic      busy;
    logic      done;
    state_t    dbg_state;

    modport master (
        input  start,
        input  abort,
        input  rf_dout,
        input  out_ready,
        output rf_ra,
        output out_valid,
        output out_idx,
        output out_data,
        output busy,
        output done,
        output dbg_state
    );

    modport slave (
        output start,
        output abort,
        output rf_dout,
        output out_ready,
        input  rf_ra,
        input  out_valid,
        input  out_idx,
        input  out_data,
        input  busy,
        input  done,
        input  dbg_state
    );

endinterface

// File: rtl/reg_dump.sv
// ---------------------------------------------------------------------------
// reg_dump
// Walks register indices FIRST_REG..LAST_REG through one read port of the
// register file and streams each value out as a valid/ready beat carrying
// the register index and its data.
//
// Parameters
//   FIRST_REG : first register index dumped
//   LAST_REG  : last register index dumped (FIRST_REG <= LAST_REG <= 31)
//
// Ports
//   clk    : sole clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : reg_dump_if.master (control, register-file read, output stream)
//
// Sequence per register: READ (address presented, data captured) followed
// by SEND (beat held until accepted), so two cycles per register at best.
// The last register goes to FIN, which pulses done for one cycle.
// ---------------------------------------------------------------------------
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic       clk,
    input  logic       resetn,
    reg_dump_if.master bus
);

    localparam reg_addr_t FIRST_IDX = reg_addr_t'(FIRST_REG);
    localparam reg_addr_t LAST_IDX  = reg_addr_t'(LAST_REG);

    state_t    r_state;
    reg_addr_t r_idx;
    logic      r_out_valid;
    reg_addr_t r_out_idx;
    data_t     r_out_data;
    logic      r_done;

    logic      w_handshake;
    logic      w_last;
    reg_addr_t w_rf_ra;

    assign w_handshake = r_out_valid && bus.out_ready;
    assign w_last      = (r_idx == LAST_IDX);

    // Read address comes only from registered state; idle parks it at 0.
    assign w_rf_ra = (r_state == ST_IDLE) ? '0 : r_idx;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // abort has nothing to cancel here, so only start matters
                    r_out_valid <= 1'b0;
                    if (bus.start) begin
                        r_idx   <= FIRST_IDX;
                        r_state <= ST_READ;
                    end
                end

                ST_READ: begin
                    if (bus.abort) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_out_data  <= bus.rf_dout;
                        r_out_idx   <= r_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    // A handshake coincident with abort still delivered the
                    // beat at this edge; abort only stops what follows.
                    if (bus.abort) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            // idx stays at LAST so it never wraps past 31
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_idx   <= r_idx + reg_addr_t'(1);
                            r_state <= ST_READ;
                        end
                    end
                end

                ST_FIN: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rf_ra     = w_rf_ra;
    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule
